// File: rtl/l1_fill_engine.sv
// ---------------------------------------------------------------------------
// l1_fill_engine
//
// Serves block-cache misses for the L1. It takes miss requests from
// NUM_PORTS lookup ports, reads the world block store (BRAM) and sends back
// fill responses tagged with the port that asked. Ports are picked by a
// round-robin arbiter. One request can be accepted every cycle, and
// responses come back in the order the requests were accepted.
//
// Ports:
//   clk_in      system clock
//   rst_in      asynchronous, active-low reset
//   req_valid   per-port miss request valid
//   req_pos     per-port block position, port i at [i*POS_W +: POS_W]
//   req_ready   per-port accept, one-hot or zero
//   bram_en     BRAM read enable
//   bram_addr   BRAM read address
//   bram_dout   BRAM read data, valid RD_LAT cycles after bram_en
//   resp_valid  single-cycle fill response strobe
//   resp_port   port the response belongs to
//   resp_pos    position being filled
//   resp_type   block type for resp_pos (0 = air when out of range)
//   busy        at least one request in flight
// ---------------------------------------------------------------------------
module l1_fill_engine #(
    parameter int NUM_PORTS  = 4,
    parameter int POS_W      = 16,
    parameter int TYPE_W     = 4,
    parameter int RD_LAT     = 2,
    parameter int WORLD_SIZE = 65536
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS*POS_W-1:0]    req_pos,
    output logic [NUM_PORTS-1:0]          req_ready,
    output logic                          bram_en,
    output logic [POS_W-1:0]              bram_addr,
    input  logic [TYPE_W-1:0]             bram_dout,
    output logic                          resp_valid,
    output logic [$clog2(NUM_PORTS)-1:0]  resp_port,
    output logic [POS_W-1:0]              resp_pos,
    output logic [TYPE_W-1:0]             resp_type,
    output logic                          busy
);

    localparam int PORT_W = $clog2(NUM_PORTS);

    // One extra bit so that WORLD_SIZE == 2**POS_W still fits.
    localparam logic [POS_W:0] WORLD_LIMIT = (POS_W+1)'(WORLD_SIZE);

    logic [PORT_W-1:0] rr_ptr;
    logic [PORT_W-1:0] grant_idx;
    logic [PORT_W-1:0] cand;
    logic              grant_found;
    logic              accept;
    logic [POS_W-1:0]  sel_pos;
    logic              sel_oob;

    logic [RD_LAT-1:0] stg_valid;
    logic [RD_LAT-1:0] stg_oob;
    logic [RD_LAT-1:0] valid_shift;
    logic [PORT_W-1:0] stg_port [RD_LAT];
    logic [POS_W-1:0]  stg_pos  [RD_LAT];

    // Round-robin scan starting at rr_ptr. The candidate index wraps
    // naturally because NUM_PORTS is a power of two.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = rr_ptr + k[PORT_W-1:0];
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Requestors see no grant while reset is held. Since ready is only
    // raised on a valid port, a grant is always a transfer.
    always_comb begin
        accept  = grant_found & rst_in;
        sel_pos = req_pos[grant_idx*POS_W +: POS_W];
        sel_oob = ({1'b0, sel_pos} >= WORLD_LIMIT);

        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end

        // Out-of-range requests skip the BRAM but still travel down the
        // pipeline so that they are answered in order, with air.
        bram_en   = accept & ~sel_oob;
        bram_addr = bram_en ? sel_pos : '0;
    end

    // Next value of the stage valids. busy is built from it so that busy
    // is registered in step with the stages.
    always_comb begin
        valid_shift    = stg_valid << 1;
        valid_shift[0] = accept;
    end

    // The arbiter pointer moves to the port just after the one that was
    // served. It holds when nothing is accepted.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= grant_idx + 1'b1;
        end
    end

    // Request pipeline. It is matched to the BRAM read latency, so the
    // last stage lines up with bram_dout for the same request.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stg_valid <= '0;
            stg_oob   <= '0;
            busy      <= 1'b0;
            for (int s = 0; s < RD_LAT; s++) begin
                stg_port[s] <= '0;
                stg_pos[s]  <= '0;
            end
        end else begin
            stg_valid   <= valid_shift;
            busy        <= |valid_shift;
            stg_oob[0]  <= sel_oob;
            stg_port[0] <= grant_idx;
            stg_pos[0]  <= sel_pos;
            for (int s = 1; s < RD_LAT; s++) begin
                stg_oob[s]  <= stg_oob[s-1];
                stg_port[s] <= stg_port[s-1];
                stg_pos[s]  <= stg_pos[s-1];
            end
        end
    end

    // Response register. It captures bram_dout on the edge where the read
    // data belongs to the last stage. The fields keep their last value
    // between responses.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            resp_valid <= 1'b0;
            resp_port  <= '0;
            resp_pos   <= '0;
            resp_type  <= '0;
        end else begin
            resp_valid <= stg_valid[RD_LAT-1];
            if (stg_valid[RD_LAT-1]) begin
                resp_port <= stg_port[RD_LAT-1];
                resp_pos  <= stg_pos[RD_LAT-1];
                resp_type <= stg_oob[RD_LAT-1] ? '0 : bram_dout;
            end
        end
    end

endmodule

// File: tb/tb_l1_fill_engine.sv
// ---------------------------------------------------------------------------
// tb_l1_fill_engine
//
// Bench for l1_fill_engine with WORLD_SIZE=1000. It contains a BRAM model
// with RD_LAT read latency and a reference model. The reference model keeps
// the round-robin pointer as an integer. It also keeps a queue of
// outstanding responses, each stamped with the clock edge on which it is
// due.
// ---------------------------------------------------------------------------
module tb_l1_fill_engine;

    localparam int NP = 4;
    localparam int PW = 16;
    localparam int TW = 4;
    localparam int RL = 2;
    localparam int WS = 1000;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b0;
    logic [NP-1:0]    req_valid = '0;
    logic [NP*PW-1:0] req_pos = '0;
    logic [NP-1:0]    req_ready;
    logic             bram_en;
    logic [PW-1:0]    bram_addr;
    logic [TW-1:0]    bram_dout;
    logic             resp_valid;
    logic [1:0]       resp_port;
    logic [PW-1:0]    resp_pos;
    logic [TW-1:0]    resp_type;
    logic             busy;

    int checks = 0;
    int errors = 0;

    l1_fill_engine #(
        .NUM_PORTS(NP), .POS_W(PW), .TYPE_W(TW), .RD_LAT(RL), .WORLD_SIZE(WS)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .req_valid(req_valid), .req_pos(req_pos),
        .req_ready(req_ready), .bram_en(bram_en), .bram_addr(bram_addr),
        .bram_dout(bram_dout), .resp_valid(resp_valid), .resp_port(resp_port),
        .resp_pos(resp_pos), .resp_type(resp_type), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    // BRAM model: the address is sampled when enabled and the data comes
    // out RL cycles after the enable.
    logic [TW-1:0] mem [0:65535];
    logic [TW-1:0] rd_pipe [RL];
    always @(posedge clk_in) begin
        if (bram_en) rd_pipe[0] <= mem[bram_addr];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_dout = rd_pipe[RL-1];

    // Reference model.
    typedef struct { int due; int port; int pos; int typ; } resp_t;
    resp_t pend[$];
    int    edge_cnt = 0;
    int    m_ptr = 0;
    logic  exp_rv = 0;
    int    exp_rp = 0, exp_rpos = 0, exp_rt = 0;
    logic  exp_busy = 0;

    function automatic int pick(input logic [NP-1:0] v, input int ptr);
        for (int k = 0; k < NP; k++)
            if (v[(ptr + k) % NP]) return (ptr + k) % NP;
        return -1;
    endfunction

    function automatic logic [NP-1:0] onehot(input int g);
        logic [NP-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [NP*PW-1:0] pack(input int p0, p1, p2, p3);
        return {p3[PW-1:0], p2[PW-1:0], p1[PW-1:0], p0[PW-1:0]};
    endfunction

    always @(posedge clk_in or negedge rst_in) begin : model
        int    g;
        resp_t r;
        if (!rst_in) begin
            pend.delete();
            m_ptr = 0; exp_rv = 0; exp_rp = 0; exp_rpos = 0; exp_rt = 0; exp_busy = 0;
        end else begin
            edge_cnt++;
            g = pick(req_valid, m_ptr);
            if (g >= 0) begin
                r.due  = edge_cnt + RL;
                r.port = g;
                r.pos  = int'(req_pos[g*PW +: PW]);
                r.typ  = (r.pos >= WS) ? 0 : int'(mem[r.pos]);
                pend.push_back(r);
                m_ptr = (g + 1) % NP;
            end
            exp_rv = 0;
            if (pend.size() > 0 && pend[0].due == edge_cnt) begin
                exp_rv = 1; exp_rp = pend[0].port; exp_rpos = pend[0].pos; exp_rt = pend[0].typ;
                void'(pend.pop_front());
            end
            exp_busy = (pend.size() > 0);
        end
    end

    // Inputs are driven at the negedge. Outputs are sampled 1 time unit
    // later, well away from the active edge.
    task automatic drive(input logic [NP-1:0] v, input logic [NP*PW-1:0] p);
        @(negedge clk_in);
        req_valid = v;
        req_pos   = p;
        #1;
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        req_pos   = pack(1, 2, 3, 4);
        #13;
        checks++; if (req_ready !== 4'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready); end
        checks++; if (bram_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_bram_en: got %b expected 0", bram_en); end
        checks++; if ({resp_valid, resp_port, resp_pos, resp_type} !== '0) begin errors++; $display("[TB] FAIL reset_resp: got v=%b p=%0d pos=%h t=%h expected all 0", resp_valid, resp_port, resp_pos, resp_type); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk_in);
        req_valid = '0;
        rst_in = 1'b1;
    endtask

    task automatic test_single();
        logic exp_v [5];
        logic exp_b [5];
        exp_v = '{0, 0, 0, 1, 0};
        exp_b = '{0, 1, 1, 0, 0};
        drive(4'b0100, pack(0, 0, 16'h0123, 0));
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL single_ready: got %b expected 0100", req_ready); end
        checks++; if (bram_en !== 1'b1 || bram_addr !== 16'h0123) begin errors++; $display("[TB] FAIL single_issue: got en=%b addr=%h expected en=1 addr=0123", bram_en, bram_addr); end
        for (int c = 1; c < 5; c++) begin
            drive('0, '0);
            checks++; if (resp_valid !== exp_v[c] || busy !== exp_b[c]) begin errors++; $display("[TB] FAIL single_timing c%0d: got v=%b busy=%b expected v=%b busy=%b", c, resp_valid, busy, exp_v[c], exp_b[c]); end
            checks++; if (c >= 3 && (resp_port !== 2'd2 || resp_pos !== 16'h0123 || resp_type !== 4'd5)) begin errors++; $display("[TB] FAIL single_data c%0d: got p=%0d pos=%h t=%h expected p=2 pos=0123 t=5", c, resp_port, resp_pos, resp_type); end
        end
    endtask

    task automatic test_all_ports();
        int q;
        // Move the pointer to 0: only port 3 requests.
        drive(4'b1000, pack(0, 0, 0, 16'h0050));
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL align_ready: got %b expected 1000", req_ready); end
        for (int c = 0; c < 16; c++) begin
            drive((c < 12) ? 4'hF : 4'h0, pack(16'h10, 16'h20, 16'h30, 16'h40));
            if (c < 12) begin
                checks++; if (req_ready !== onehot(c % 4) || bram_addr !== PW'(16 * (c % 4 + 1))) begin errors++; $display("[TB] FAIL rr_grant c%0d: got rdy=%b addr=%h expected rdy=%b addr=%h", c, req_ready, bram_addr, onehot(c % 4), 16 * (c % 4 + 1)); end
            end
            if (c >= 3) begin
                q = (c - 3) % 4;
                checks++;
                if (resp_valid !== (c < 15) || (c < 15 && (resp_port !== 2'(q) || resp_pos !== PW'(16 * (q + 1)) || resp_type !== mem[16 * (q + 1)]))) begin
                    errors++; $display("[TB] FAIL rr_resp c%0d: got v=%b p=%0d pos=%h t=%h expected v=%b p=%0d pos=%h t=%h", c, resp_valid, resp_port, resp_pos, resp_type, c < 15, q, 16 * (q + 1), mem[16 * (q + 1)]);
                end
            end
        end
    endtask

    task automatic test_fairness();
        logic [NP-1:0] want [3];
        want = '{4'b1000, 4'b0001, 4'b1000};
        drive(4'b0010, pack(0, 16'h0007, 0, 0));
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL fair_setup: got %b expected 0010", req_ready); end
        for (int c = 0; c < 3; c++) begin
            drive(4'b1001, pack(16'h0100, 0, 0, 16'h0200));
            checks++; if (req_ready !== want[c]) begin errors++; $display("[TB] FAIL fair_grant c%0d: got %b expected %b", c, req_ready, want[c]); end
        end
        for (int c = 0; c <= RL; c++) drive('0, '0);
    endtask

    task automatic test_oob();
        drive(4'b0001, pack(WS, 0, 0, 0));
        checks++; if (req_ready !== 4'b0001 || bram_en !== 1'b0 || bram_addr !== 16'd0) begin errors++; $display("[TB] FAIL oob_issue: got rdy=%b en=%b addr=%h expected rdy=0001 en=0 addr=0000", req_ready, bram_en, bram_addr); end
        drive(4'b0010, pack(0, WS - 1, 0, 0));
        checks++; if (req_ready !== 4'b0010 || bram_en !== 1'b1 || bram_addr !== PW'(WS - 1)) begin errors++; $display("[TB] FAIL edge_issue: got rdy=%b en=%b addr=%h expected rdy=0010 en=1 addr=%h", req_ready, bram_en, bram_addr, WS - 1); end
        for (int c = 2; c < 5; c++) begin
            drive('0, '0);
            if (c == 3) begin
                checks++; if (resp_valid !== 1'b1 || resp_port !== 2'd0 || resp_pos !== PW'(WS) || resp_type !== 4'd0) begin errors++; $display("[TB] FAIL oob_resp: got v=%b p=%0d pos=%0d t=%0d expected v=1 p=0 pos=%0d t=0", resp_valid, resp_port, resp_pos, resp_type, WS); end
            end
            if (c == 4) begin
                checks++; if (resp_valid !== 1'b1 || resp_port !== 2'd1 || resp_pos !== PW'(WS - 1) || resp_type !== mem[WS - 1]) begin errors++; $display("[TB] FAIL edge_resp: got v=%b p=%0d pos=%0d t=%0d expected v=1 p=1 pos=%0d t=%0d", resp_valid, resp_port, resp_pos, resp_type, WS - 1, mem[WS - 1]); end
            end
        end
        drive('0, '0);
    endtask

    task automatic test_random();
        int g, p;
        int pos [NP];
        logic [NP-1:0] v;
        for (int c = 0; c < 304; c++) begin
            v = (c < 300) ? NP'($urandom_range(0, 15)) : '0;
            for (int i = 0; i < NP; i++) begin
                case ($urandom_range(0, 3))
                    0: pos[i] = $urandom_range(WS - 2, WS + 1);
                    1: pos[i] = $urandom_range(0, WS - 1);
                    default: pos[i] = $urandom_range(0, 65535);
                endcase
            end
            drive(v, pack(pos[0], pos[1], pos[2], pos[3]));
            g = pick(req_valid, m_ptr);
            p = (g >= 0) ? pos[g] : 0;
            checks++; if (req_ready !== onehot(g)) begin errors++; $display("[TB] FAIL rand_ready c%0d: got %b expected %b", c, req_ready, onehot(g)); end
            checks++;
            if (bram_en !== (g >= 0 && p < WS) || bram_addr !== ((g >= 0 && p < WS) ? PW'(p) : '0)) begin
                errors++; $display("[TB] FAIL rand_issue c%0d: got en=%b addr=%h expected en=%b addr=%h", c, bram_en, bram_addr, g >= 0 && p < WS, (g >= 0 && p < WS) ? p : 0);
            end
            checks++;
            if (resp_valid !== exp_rv || resp_port !== 2'(exp_rp) || resp_pos !== PW'(exp_rpos) || resp_type !== TW'(exp_rt) || busy !== exp_busy) begin
                errors++; $display("[TB] FAIL rand_resp c%0d: got v=%b p=%0d pos=%h t=%h busy=%b expected v=%b p=%0d pos=%h t=%h busy=%b", c, resp_valid, resp_port, resp_pos, resp_type, busy, exp_rv, exp_rp, exp_rpos, exp_rt, exp_busy);
            end
        end
    endtask

    task automatic test_reset_midflight();
        drive(4'b0001, pack(16'h0011, 0, 0, 0));
        drive(4'b0010, pack(0, 16'h0022, 0, 0));
        @(negedge clk_in);
        req_valid = '0;
        #2 rst_in = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midflight_reset: got v=%b busy=%b expected 0 0", resp_valid, busy); end
        @(negedge clk_in);
        rst_in = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive('0, '0);
            checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midflight_ghost c%0d: got v=%b busy=%b expected 0 0", c, resp_valid, busy); end
        end
        drive(4'hF, pack(1, 2, 3, 4));
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL midflight_ptr: got %b expected 0001", req_ready); end
        for (int c = 0; c <= RL; c++) drive('0, '0);
    endtask

    task automatic test_idle();
        for (int c = 0; c < 20; c++) begin
            drive('0, pack(5, 6, 7, 8));
            checks++;
            if (req_ready !== 4'b0 || bram_en !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("[TB] FAIL idle c%0d: got rdy=%b en=%b v=%b busy=%b expected all 0", c, req_ready, bram_en, resp_valid, busy);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = TW'($urandom_range(1, 15));
        mem[16'h0123] = 4'd5;
        test_reset();
        test_single();
        test_all_ports();
        test_fairness();
        test_oob();
        test_random();
        test_reset_midflight();
        test_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
